// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler sharing one K-bit multiplexer among 2^N requesters.
// The selected word is captured into a registered output stage and offered
// downstream over valid/ready. Grants rotate from a pointer that advances
// past the last served requester once its word has been accepted.

module generic_mux #(
    parameter int N = 2,
    parameter int K = 8
) (
    input  logic [(2**N)*K-1:0] D,
    input  logic [N-1:0]        S,
    output logic [K-1:0]        Y
);
    // Plain indexed word select
    assign Y = D[S*K +: K];
endmodule

module rr_mux_scheduler #(
    parameter int N = 2,
    parameter int K = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [(2**N)-1:0]     req_valid,
    input  logic [(2**N)*K-1:0]   req_data,
    output logic [(2**N)-1:0]     req_ready,
    output logic                  out_valid,
    output logic [K-1:0]          out_data,
    output logic [N-1:0]          out_src,
    input  logic                  out_ready,
    output logic [N-1:0]          sel,
    output logic                  busy
);
    localparam int NR = 2**N;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_r, state_nx_s;
    logic [N-1:0]    ptr_r, ptr_nx_s;
    logic [N-1:0]    out_src_r, out_src_nx_s;
    logic [K-1:0]    out_data_r, out_data_nx_s;
    logic            out_valid_r, out_valid_nx_s;
    logic [N-1:0]    grant_idx_s;
    logic            any_req_s;
    logic [N-1:0]    sel_s;
    logic [K-1:0]    mux_y_s;
    logic [NR-1:0]   req_ready_s;

    // Shared datapath multiplexer; its output is the capture source
    generic_mux #(.N(N), .K(K)) u_mux (
        .D (req_data),
        .S (sel_s),
        .Y (mux_y_s)
    );

    // Rotating priority search: first valid requester starting at ptr
    always_comb begin
        logic [N-1:0] cand;
        logic         found;
        grant_idx_s = ptr_r;
        found       = 1'b0;
        cand        = ptr_r;
        for (int k = 0; k < NR; k++) begin
            cand = ptr_r + N'(k);
            if (!found && req_valid[cand]) begin
                grant_idx_s = cand;
                found       = 1'b1;
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        any_req_s = |req_valid;
    end

    // Next-state, select and handshake decode
    always_comb begin
        state_nx_s     = state_r;
        ptr_nx_s       = ptr_r;
        out_src_nx_s   = out_src_r;
        out_data_nx_s  = out_data_r;
        out_valid_nx_s = out_valid_r;
        sel_s          = ptr_r;
        req_ready_s    = {NR{1'b0}};
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    sel_s                    = grant_idx_s;
                    req_ready_s[grant_idx_s] = 1'b1;
                    out_data_nx_s            = mux_y_s;
                    out_src_nx_s             = grant_idx_s;
                    out_valid_nx_s           = 1'b1;
                    state_nx_s               = SEND;
                end else begin
                    sel_s = ptr_r;
                end
            end
            SEND: begin
                // Mux points back at the served requester; word is held
                sel_s = out_src_r;
                if (out_ready) begin
                    out_valid_nx_s = 1'b0;
                    ptr_nx_s       = out_src_r + {{(N-1){1'b0}}, 1'b1};
                    state_nx_s     = IDLE;
                end else begin
                    out_valid_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s     = IDLE;
                out_valid_nx_s = 1'b0;
            end
        endcase
    end

    // State, pointer and output stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {N{1'b0}};
            out_src_r   <= {N{1'b0}};
            out_data_r  <= {K{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            ptr_r       <= ptr_nx_s;
            out_src_r   <= out_src_nx_s;
            out_data_r  <= out_data_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    // Ready is held low while reset is asserted, whatever req_valid does
    assign req_ready = rst_n ? req_ready_s : {NR{1'b0}};
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign sel       = sel_s;
    assign busy      = (state_r == SEND);

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Bench for rr_mux_scheduler (N=2, K=8): directed scenarios with literal
// expectations plus a randomized phase, all compared against a transaction
// level model of the scheduler kept in the bench.

module tb_rr_mux_scheduler;
    localparam int N  = 2;
    localparam int K  = 8;
    localparam int NR = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [31:0]   req_data;
    logic [3:0]    req_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [1:0]    out_src;
    logic          out_ready;
    logic [1:0]    sel;
    logic          busy;

    int tests;
    int failed;

    // model state: is a word pending downstream, which one, and the pointer
    bit       m_busy;
    int       m_ptr;
    int       m_src;
    bit [7:0] m_data;

    rr_mux_scheduler #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_src  = 0;
        m_data = 8'h00;
    endtask

    // One clock cycle: drive inputs, compare everything against the model,
    // then advance the model across the coming rising edge.
    task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic rdy);
        int   grant;
        bit   any;
        logic [3:0] exp_rr;
        logic [1:0] exp_sel;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        out_ready = rdy;
        #1;
        any   = (v != 4'b0000);
        grant = m_ptr;
        for (int k = NR - 1; k >= 0; k--) begin
            if (v[(m_ptr + k) % NR]) grant = (m_ptr + k) % NR;
        end
        exp_rr  = (!m_busy && any) ? (4'b0001 << grant) : 4'b0000;
        exp_sel = m_busy ? 2'(m_src) : 2'(any ? grant : m_ptr);
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
        chk("busy",      {31'd0, busy},      {31'd0, m_busy});
        chk("sel",       {30'd0, sel},       {30'd0, exp_sel});
        if (m_busy) begin
            chk("out_data", {24'd0, out_data}, {24'd0, m_data});
            chk("out_src",  {30'd0, out_src},  32'(m_src));
        end
        if (!m_busy && any) begin
            m_busy = 1'b1;
            m_src  = grant;
            m_data = d[grant*8 +: 8];
        end else if (m_busy && rdy) begin
            m_busy = 1'b0;
            m_ptr  = (m_src + 1) % NR;
        end
    endtask

    // Asynchronous reset asserted between edges, with requests still driven
    task automatic do_reset(input logic [3:0] v);
        @(negedge clk);
        req_valid = v;
        req_data  = $urandom;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_data",  {24'd0, out_data},  32'd0);
        chk("rst out_src",   {30'd0, out_src},   32'd0);
        chk("rst req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst busy",      {31'd0, busy},      32'd0);
        model_reset();
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'd0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single request from requester 2
        cyc(4'b0100, 32'h00A5_0000, 1'b1);
        chk("s2 req_ready", {28'd0, req_ready}, 32'h4);
        cyc(4'b0000, 32'h0000_0000, 1'b1);
        chk("s2 out_valid", {31'd0, out_valid}, 32'd1);
        chk("s2 out_data",  {24'd0, out_data},  32'hA5);
        chk("s2 out_src",   {30'd0, out_src},   32'd2);
        cyc(4'b0000, 32'h0000_0000, 1'b1);
        chk("s2 ptr", {30'd0, sel}, 32'd3);

        // reset mid-simulation while requests are present
        do_reset(4'b1111);

        // all requesters valid: rotation 0,1,2,3,0
        for (int t = 0; t < 10; t++) begin
            cyc(4'b1111, 32'h1312_1110, 1'b1);
            if (t % 2 == 1) begin
                chk("s3 out_valid", {31'd0, out_valid}, 32'd1);
                chk("s3 out_src",   {30'd0, out_src},   32'(((t - 1) / 2) % 4));
                chk("s3 out_data",  {24'd0, out_data},  32'h10 + 32'(((t - 1) / 2) % 4));
            end else begin
                chk("s3 gap", {31'd0, out_valid}, 32'd0);
            end
        end

        // backpressure on a captured 0x3C from requester 1
        cyc(4'b0010, 32'h0000_3C00, 1'b0);
        for (int t = 0; t < 5; t++) begin
            cyc(4'b1111, 32'hFFFF_FFFF, 1'b0);
            chk("s4 out_valid", {31'd0, out_valid}, 32'd1);
            chk("s4 out_data",  {24'd0, out_data},  32'h3C);
            chk("s4 req_ready", {28'd0, req_ready}, 32'd0);
            chk("s4 busy",      {31'd0, busy},      32'd1);
        end
        cyc(4'b1111, 32'hFFFF_FFFF, 1'b1);
        cyc(4'b0000, 32'h0000_0000, 1'b1);
        chk("s4 released", {31'd0, out_valid}, 32'd0);

        // wrap-around: grant 2, then 0011 gives 0 before 1
        cyc(4'b0100, 32'h0077_0000, 1'b1);
        chk("s5 grant2", {28'd0, req_ready}, 32'h4);
        cyc(4'b0000, 32'h0000_0000, 1'b1);
        cyc(4'b0011, 32'h0000_2221, 1'b1);
        chk("s5 grant0", {28'd0, req_ready}, 32'h1);
        cyc(4'b0011, 32'h0000_2221, 1'b1);
        chk("s5 src0", {30'd0, out_src}, 32'd0);
        cyc(4'b0011, 32'h0000_2221, 1'b1);
        chk("s5 grant1", {28'd0, req_ready}, 32'h2);

        // reset during SEND under backpressure
        cyc(4'b1111, 32'h4433_2211, 1'b0);
        cyc(4'b0000, 32'h0000_0000, 1'b0);
        chk("s6 pending", {31'd0, out_valid}, 32'd1);
        do_reset(4'b0000);
        cyc(4'b0000, 32'h0000_0000, 1'b0);
        chk("s6 ptr0", {30'd0, sel}, 32'd0);
        cyc(4'b1000, 32'h5A00_0000, 1'b1);
        chk("s6 grant3", {28'd0, req_ready}, 32'h8);
        chk("s6 sel3",   {30'd0, sel},       32'd3);

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            logic [3:0] v;
            v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            cyc(v, $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
